// File: rtl/bounce_sched.sv
// Time-multiplexed motion controller for up to N_OBJ bouncing squares.
// One shared add/compare unit updates one axis of one object per cycle.
module bounce_sched #(
  parameter int CORDW      = 10,
  parameter int N_OBJ      = 4,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int Q_SIZE     = 200,
  parameter int FRAME_NUM  = 1,
  parameter int INIT_SPEED = 2
) (
  input  logic                   clk_pix,
  input  logic                   rst_pix,
  input  logic                   frame,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_idx,
  input  logic [CORDW-1:0]       cfg_x,
  input  logic [CORDW-1:0]       cfg_y,
  input  logic [CORDW-1:0]       cfg_speed,
  input  logic                   cfg_dx,
  input  logic                   cfg_dy,
  output logic                   cfg_ready,
  output logic [N_OBJ*CORDW-1:0] qx_all,
  output logic [N_OBJ*CORDW-1:0] qy_all,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int FW = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1;
  localparam int W  = CORDW + 2;

  localparam logic [IW-1:0]    LAST_IDX  = IW'(N_OBJ - 1);
  localparam logic [FW-1:0]    LAST_FRM  = FW'(FRAME_NUM - 1);
  localparam logic [W-1:0]     X_LIM     = W'(H_RES - 1);
  localparam logic [W-1:0]     Y_LIM     = W'(V_RES - 1);
  localparam logic [CORDW-1:0] X_STOP    = CORDW'(H_RES - Q_SIZE - 1);
  localparam logic [CORDW-1:0] Y_STOP    = CORDW'(V_RES - Q_SIZE - 1);

  typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, DONE} state_t;

  state_t state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic [FW-1:0] frame_cnt;

  logic [CORDW-1:0] qx  [N_OBJ];
  logic [CORDW-1:0] qy  [N_OBJ];
  logic [CORDW-1:0] spd [N_OBJ];
  logic             dx  [N_OBJ];
  logic             dy  [N_OBJ];

  logic             go;
  logic             cfg_ok;
  logic [IW-1:0]    cfg_sel;
  logic [CORDW-1:0] pos_sel, spd_sel, pos_new, stop_sel;
  logic [W-1:0]     lim_sel;
  logic             dir_sel, dir_new, hit_far;

  assign go        = frame && (state == IDLE) && (frame_cnt == '0);
  assign cfg_ready = (state == IDLE);
  assign cfg_ok    = cfg_we && cfg_ready && ({1'b0, cfg_idx} < 5'(N_OBJ));
  assign cfg_sel   = cfg_idx[IW-1:0];
  assign busy      = (state == UPD_X) || (state == UPD_Y);
  assign done      = (state == DONE);

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: if (go) begin
        state_next = UPD_X;
        idx_next   = '0;
      end
      UPD_X: state_next = UPD_Y;
      UPD_Y: begin
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          state_next = UPD_X;
          idx_next   = idx + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frames only advance the divider while idle; frames during a sweep just flag overrun.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= frame && (state != IDLE);
      if (frame && (state == IDLE))
        frame_cnt <= (frame_cnt == LAST_FRM) ? '0 : frame_cnt + 1'b1;
    end
  end

  always_comb begin
    spd_sel  = spd[idx];
    pos_sel  = qx[idx];
    dir_sel  = dx[idx];
    lim_sel  = X_LIM;
    stop_sel = X_STOP;
    if (state == UPD_Y) begin
      pos_sel  = qy[idx];
      dir_sel  = dy[idx];
      lim_sel  = Y_LIM;
      stop_sel = Y_STOP;
    end
    hit_far = ({2'b00, pos_sel} + W'(Q_SIZE) + {2'b00, spd_sel}) >= lim_sel;
    pos_new = pos_sel;
    dir_new = dir_sel;
    if (!dir_sel) begin
      if (hit_far) begin
        pos_new = stop_sel;
        dir_new = 1'b1;
      end else begin
        pos_new = pos_sel + spd_sel;
      end
    end else begin
      if (pos_sel < spd_sel) begin
        pos_new = '0;
        dir_new = 1'b0;
      end else begin
        pos_new = pos_sel - spd_sel;
      end
    end
  end

  // Config writes only happen in IDLE and updates only while busy, so they never collide.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      for (int k = 0; k < N_OBJ; k++) begin
        qx[k]  <= '0;
        qy[k]  <= '0;
        dx[k]  <= 1'b0;
        dy[k]  <= 1'b0;
        spd[k] <= CORDW'(INIT_SPEED);
      end
    end else if (cfg_ok) begin
      qx[cfg_sel]  <= cfg_x;
      qy[cfg_sel]  <= cfg_y;
      spd[cfg_sel] <= cfg_speed;
      dx[cfg_sel]  <= cfg_dx;
      dy[cfg_sel]  <= cfg_dy;
    end else if (state == UPD_X) begin
      qx[idx] <= pos_new;
      dx[idx] <= dir_new;
    end else if (state == UPD_Y) begin
      qy[idx] <= pos_new;
      dy[idx] <= dir_new;
    end
  end

  for (genvar k = 0; k < N_OBJ; k++) begin : g_flat
    assign qx_all[k*CORDW +: CORDW] = qx[k];
    assign qy_all[k*CORDW +: CORDW] = qy[k];
  end

endmodule

// File: tb/tb_bounce_sched.sv
// Directed bench for bounce_sched: one instance at FRAME_NUM=1 for motion,
// timing and config, a second at FRAME_NUM=3 for the frame divider.
module tb_bounce_sched;

  localparam int CORDW = 10;
  localparam int N_OBJ = 4;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  logic frame_a = 1'b0;
  logic frame_b = 1'b0;
  logic cfg_we = 1'b0;
  logic [3:0] cfg_idx = '0;
  logic [CORDW-1:0] cfg_x = '0, cfg_y = '0, cfg_speed = '0;
  logic cfg_dx = 1'b0, cfg_dy = 1'b0;

  logic cfg_ready_a, busy_a, done_a, overrun_a;
  logic [N_OBJ*CORDW-1:0] qx_all_a, qy_all_a;
  logic cfg_ready_b, busy_b, done_b, overrun_b;
  logic [N_OBJ*CORDW-1:0] qx_all_b, qy_all_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_pix = ~clk_pix;

  bounce_sched #(.CORDW(CORDW), .N_OBJ(N_OBJ)) dut_a (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame_a),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_speed(cfg_speed), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
    .cfg_ready(cfg_ready_a), .qx_all(qx_all_a), .qy_all(qy_all_a),
    .busy(busy_a), .done(done_a), .overrun(overrun_a)
  );

  bounce_sched #(.CORDW(CORDW), .N_OBJ(N_OBJ), .FRAME_NUM(3)) dut_b (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame_b),
    .cfg_we(1'b0), .cfg_idx(4'd0), .cfg_x(10'd0), .cfg_y(10'd0),
    .cfg_speed(10'd0), .cfg_dx(1'b0), .cfg_dy(1'b0),
    .cfg_ready(cfg_ready_b), .qx_all(qx_all_b), .qy_all(qy_all_b),
    .busy(busy_b), .done(done_b), .overrun(overrun_b)
  );

  function automatic logic [N_OBJ*CORDW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {CORDW'(d), CORDW'(c), CORDW'(b), CORDW'(a)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive one cycle of inputs at a negedge, then move to the next negedge.
  task automatic applyStimulus(input logic we, input int idx, input int x, input int y,
                               input int spd, input logic dxv, input logic dyv,
                               input logic fa, input logic fb);
    cfg_we    = we;
    cfg_idx   = 4'(idx);
    cfg_x     = CORDW'(x);
    cfg_y     = CORDW'(y);
    cfg_speed = CORDW'(spd);
    cfg_dx    = dxv;
    cfg_dy    = dyv;
    frame_a   = fa;
    frame_b   = fb;
    @(negedge clk_pix);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runSweep();
    int done_cnt;
    done_cnt = 0;
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (done_a) done_cnt++;
      idle();
    end
    checkOutput("sweep_done_count", 64'(done_cnt), 64'd1);
  endtask

  task automatic frameB(input logic expect_sweep);
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("b_busy_after_frame", 64'(busy_b), 64'(expect_sweep));
    repeat (10) idle();
  endtask

  initial begin
    int done_cnt;
    @(negedge clk_pix);
    repeat (3) idle();
    rst_pix = 1'b0;
    checkOutput("rst_busy", 64'(busy_a), 64'd0);
    checkOutput("rst_done", 64'(done_a), 64'd0);
    checkOutput("rst_overrun", 64'(overrun_a), 64'd0);
    checkOutput("rst_cfg_ready", 64'(cfg_ready_a), 64'd1);
    checkOutput("rst_qx", 64'(qx_all_a), 64'd0);
    checkOutput("rst_qy", 64'(qy_all_a), 64'd0);

    // First sweep after reset with cycle-exact timing checks.
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      checkOutput("first_busy", 64'(busy_a), 64'd1);
      if (c == 1) checkOutput("first_qx_t1", 64'(qx_all_a), 64'd0);
      if (c == 2) checkOutput("first_qx_t2", 64'(qx_all_a), 64'(pack4(2, 0, 0, 0)));
      if (c == 2) checkOutput("first_qy_t2", 64'(qy_all_a), 64'd0);
      if (c == 3) checkOutput("first_qy_t3", 64'(qy_all_a), 64'(pack4(2, 0, 0, 0)));
      idle();
    end
    checkOutput("first_done_t9", 64'(done_a), 64'd1);
    checkOutput("first_busy_t9", 64'(busy_a), 64'd0);
    checkOutput("first_ready_t9", 64'(cfg_ready_a), 64'd0);
    idle();
    checkOutput("first_done_t10", 64'(done_a), 64'd0);
    checkOutput("first_qx", 64'(qx_all_a), 64'(pack4(2, 2, 2, 2)));
    checkOutput("first_qy", 64'(qy_all_a), 64'(pack4(2, 2, 2, 2)));

    // Object 1 bounces off the right edge.
    applyStimulus(1'b1, 1, 436, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cfg1_written", 64'(qx_all_a), 64'(pack4(2, 436, 2, 2)));
    runSweep();
    checkOutput("right_x_438", 64'(qx_all_a), 64'(pack4(4, 438, 4, 4)));
    checkOutput("right_y", 64'(qy_all_a), 64'(pack4(4, 4, 4, 4)));
    runSweep();
    checkOutput("right_x_439", 64'(qx_all_a), 64'(pack4(6, 439, 6, 6)));
    runSweep();
    checkOutput("right_x_437", 64'(qx_all_a), 64'(pack4(8, 437, 8, 8)));
    checkOutput("right_y_8", 64'(qy_all_a), 64'(pack4(8, 8, 8, 8)));

    // Object 2 bounces off the top edge.
    applyStimulus(1'b1, 2, 8, 1, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    runSweep();
    checkOutput("top_y_0", 64'(qy_all_a), 64'(pack4(10, 10, 0, 10)));
    checkOutput("top_x", 64'(qx_all_a), 64'(pack4(10, 435, 10, 10)));
    runSweep();
    checkOutput("top_y_2", 64'(qy_all_a), 64'(pack4(12, 12, 2, 12)));

    // Frame arriving 3 cycles into a sweep.
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ovr_pulse", 64'(overrun_a), 64'd1);
    checkOutput("ovr_busy", 64'(busy_a), 64'd1);
    idle();
    checkOutput("ovr_pulse_end", 64'(overrun_a), 64'd0);
    repeat (4) idle();
    checkOutput("ovr_done_t9", 64'(done_a), 64'd1);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (busy_a || done_a) done_cnt++;
    end
    checkOutput("ovr_no_extra_sweep", 64'(done_cnt), 64'd0);
    checkOutput("ovr_qx", 64'(qx_all_a), 64'(pack4(14, 431, 14, 14)));
    checkOutput("ovr_qy", 64'(qy_all_a), 64'(pack4(14, 14, 4, 14)));

    // Config write while busy is dropped; out-of-range index is dropped.
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    checkOutput("busy_cfg_ready", 64'(cfg_ready_a), 64'd0);
    applyStimulus(1'b1, 3, 300, 300, 9, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) idle();
    checkOutput("busy_cfg_drop_x", 64'(qx_all_a), 64'(pack4(16, 429, 16, 16)));
    checkOutput("busy_cfg_drop_y", 64'(qy_all_a), 64'(pack4(16, 16, 6, 16)));
    applyStimulus(1'b1, 4, 500, 500, 9, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("idx4_drop_x", 64'(qx_all_a), 64'(pack4(16, 429, 16, 16)));
    checkOutput("idx4_drop_y", 64'(qy_all_a), 64'(pack4(16, 16, 6, 16)));

    // Config write together with a qualifying frame.
    applyStimulus(1'b1, 0, 100, 16, 5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    checkOutput("cfg_frame_t2", 64'(qx_all_a), 64'(pack4(105, 429, 16, 16)));
    repeat (8) idle();
    checkOutput("cfg_frame_qx", 64'(qx_all_a), 64'(pack4(105, 427, 18, 18)));
    checkOutput("cfg_frame_qy", 64'(qy_all_a), 64'(pack4(21, 18, 8, 18)));

    // Reset in the middle of a sweep.
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();
    rst_pix = 1'b1;
    idle();
    rst_pix = 1'b0;
    checkOutput("midrst_busy", 64'(busy_a), 64'd0);
    checkOutput("midrst_ready", 64'(cfg_ready_a), 64'd1);
    checkOutput("midrst_qx", 64'(qx_all_a), 64'd0);
    checkOutput("midrst_qy", 64'(qy_all_a), 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (done_a || busy_a) done_cnt++;
      idle();
    end
    checkOutput("midrst_no_done", 64'(done_cnt), 64'd0);
    runSweep();
    checkOutput("midrst_speed_qx", 64'(qx_all_a), 64'(pack4(2, 2, 2, 2)));
    checkOutput("midrst_speed_qy", 64'(qy_all_a), 64'(pack4(2, 2, 2, 2)));

    // FRAME_NUM=3 divider with an ignored frame during the first sweep.
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("b_f0_busy", 64'(busy_b), 64'd1);
    idle();
    idle();
    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("b_overrun", 64'(overrun_b), 64'd1);
    repeat (8) idle();
    checkOutput("b_f0_qx", 64'(qx_all_b), 64'(pack4(2, 2, 2, 2)));
    frameB(1'b0);
    frameB(1'b0);
    checkOutput("b_f2_qx", 64'(qx_all_b), 64'(pack4(2, 2, 2, 2)));
    frameB(1'b1);
    checkOutput("b_f3_qx", 64'(qx_all_b), 64'(pack4(4, 4, 4, 4)));
    frameB(1'b0);
    frameB(1'b0);
    checkOutput("b_f5_qx", 64'(qx_all_b), 64'(pack4(4, 4, 4, 4)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
